// File: rtl/ns_pkg.sv
// ns_pkg: shared types and constants for the channel arbiter and the protocol model.
// Holds the arbiter state encoding, the agent-index width, the agent role indices
// and the rotating-priority distance helper used by the picker and the top.
package ns_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, SNOOP, BUSY} arb_state_t;

    localparam int AGENT_IW       = 2;
    localparam int NUM_AGENTS_DEF = 3;
    localparam int INITIATOR_IDX  = 0;
    localparam int RESPONDER_IDX  = 1;
    localparam int INTRUDER_IDX   = 2;

    // Scan position of agent idx when the scan starts just after agent last.
    function automatic int rr_dist(input int idx, input int last, input int n);
        return idx > last ? idx - last - 1 : idx + n - last - 1;
    endfunction

endpackage

// File: rtl/ns_rr_pick.sv
// ns_rr_pick: combinational rotating-priority picker.
// Ports: req_i   - candidate request vector
//        last_i  - last granted index; scanning starts at last_i+1 mod NUM_AGENTS
//        idx_o   - first requesting index in scan order
//        found_o - at least one request present
module ns_rr_pick
    import ns_pkg::*;
#(
    parameter int NUM_AGENTS = NUM_AGENTS_DEF,
    parameter int MSB        = AGENT_IW - 1
) (
    input  logic [NUM_AGENTS-1:0] req_i,
    input  logic [MSB:0]          last_i,
    output logic [MSB:0]          idx_o,
    output logic                  found_o
);

    localparam int IW = MSB + 1;

    int best;

    always_comb begin
        best  = NUM_AGENTS;
        idx_o = '0;
        for (int i = 0; i < NUM_AGENTS; i++)
            if (req_i[i] && rr_dist(i, int'(last_i), NUM_AGENTS) < best) begin
                best  = rr_dist(i, int'(last_i), NUM_AGENTS);
                idx_o = IW'(i);
            end
        found_o = |req_i;
    end

endmodule

// File: rtl/ns_channel_arbiter.sv
// ns_channel_arbiter: round-robin scheduler for the single shared protocol channel.
// Optional snoop slot enabled by defining NS_CHANNEL_ARBITER_SNOOP_EN.
// Ports: clock_i/reset_i   - clock, asynchronous active-high reset
//        send_req_i        - per-agent send request
//        send_dst_i        - packed per-agent destination, agent i at [i*(MSB+1) +: MSB+1]
//        done_i            - per-agent consumption of the in-flight message
//        grant_valid_o     - one-cycle send grant
//        grant_src_o/dst_o - selected sender / destination (selectS / selectO)
//        chan_busy_o       - message in flight
//        drop_o            - one-cycle pulse when an undelivered message times out
//        req_err_o         - one-cycle pulse when an illegal request is skipped
//        snoop_valid_o     - intruder snoop slot
module ns_channel_arbiter
    import ns_pkg::*;
#(
    parameter int NUM_AGENTS  = NUM_AGENTS_DEF,
    parameter int MSB         = AGENT_IW - 1,
    parameter int TIMEOUT     = 6,
    parameter int TW          = 3
`ifdef NS_CHANNEL_ARBITER_SNOOP_EN
    , parameter int SNOOP_AGENT = INTRUDER_IDX
`endif
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [NUM_AGENTS-1:0]         send_req_i,
    input  logic [NUM_AGENTS*(MSB+1)-1:0] send_dst_i,
    input  logic [NUM_AGENTS-1:0]         done_i,
    output logic                          grant_valid_o,
    output logic [MSB:0]                  grant_src_o,
    output logic [MSB:0]                  grant_dst_o,
    output logic                          chan_busy_o,
    output logic                          drop_o,
    output logic                          req_err_o,
    output logic                          snoop_valid_o
);

    localparam int IW = MSB + 1;

    arb_state_t            state_q;
    logic [MSB:0]          rr_last_q, grant_src_q, grant_dst_q;
    logic [TW-1:0]         timer_q;
    logic                  grant_valid_q, chan_busy_q, drop_q, req_err_q;
    logic [MSB:0]          dst_a [NUM_AGENTS];
    logic [NUM_AGENTS-1:0] legal;
    logic [MSB:0]          win_idx, ill_idx, dst_d;
    logic                  win_found, ill_found, req_err_d;

    always_comb begin
        for (int i = 0; i < NUM_AGENTS; i++) begin
            dst_a[i] = send_dst_i[i*IW +: IW];
            legal[i] = int'(dst_a[i]) != i && int'(dst_a[i]) < NUM_AGENTS;
        end
    end

    ns_rr_pick #(.NUM_AGENTS(NUM_AGENTS), .MSB(MSB)) u_pick_legal (
        .req_i  (send_req_i & legal),
        .last_i (rr_last_q),
        .idx_o  (win_idx),
        .found_o(win_found)
    );

    ns_rr_pick #(.NUM_AGENTS(NUM_AGENTS), .MSB(MSB)) u_pick_illegal (
        .req_i  (send_req_i & ~legal),
        .last_i (rr_last_q),
        .idx_o  (ill_idx),
        .found_o(ill_found)
    );

    assign dst_d = dst_a[win_idx];
    // An illegal requester only counts if the scan meets it before the winner.
    assign req_err_d = ill_found && (!win_found ||
        rr_dist(int'(ill_idx), int'(rr_last_q), NUM_AGENTS) <
        rr_dist(int'(win_idx), int'(rr_last_q), NUM_AGENTS));

`ifdef NS_CHANNEL_ARBITER_SNOOP_EN
    logic snoop_valid_q;
    assign snoop_valid_o = snoop_valid_q;
`else
    assign snoop_valid_o = 1'b0;
`endif

    // rr_last_q doubles as the latched sender for the whole transaction.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            rr_last_q     <= IW'(NUM_AGENTS - 1);
            grant_src_q   <= '0;
            grant_dst_q   <= '0;
            timer_q       <= '0;
            grant_valid_q <= 1'b0;
            chan_busy_q   <= 1'b0;
            drop_q        <= 1'b0;
            req_err_q     <= 1'b0;
`ifdef NS_CHANNEL_ARBITER_SNOOP_EN
            snoop_valid_q <= 1'b0;
`endif
        end else begin
            grant_valid_q <= 1'b0;
            drop_q        <= 1'b0;
            req_err_q     <= 1'b0;
`ifdef NS_CHANNEL_ARBITER_SNOOP_EN
            snoop_valid_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    req_err_q <= req_err_d;
                    if (win_found) begin
                        state_q       <= GRANT;
                        rr_last_q     <= win_idx;
                        grant_src_q   <= win_idx;
                        grant_dst_q   <= dst_d;
                        grant_valid_q <= 1'b1;
                    end
                end
                GRANT: begin
                    chan_busy_q <= 1'b1;
`ifdef NS_CHANNEL_ARBITER_SNOOP_EN
                    if (int'(rr_last_q) != SNOOP_AGENT) begin
                        state_q       <= SNOOP;
                        snoop_valid_q <= 1'b1;
                        grant_src_q   <= IW'(SNOOP_AGENT);
                    end else
                        state_q <= BUSY;
`else
                    state_q <= BUSY;
`endif
                end
                SNOOP: begin
                    state_q     <= BUSY;
                    grant_src_q <= rr_last_q;
                end
                BUSY: begin
                    timer_q <= timer_q + 1'b1;
                    if (done_i[grant_dst_q]) begin
                        state_q     <= IDLE;
                        timer_q     <= '0;
                        chan_busy_q <= 1'b0;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        state_q     <= IDLE;
                        timer_q     <= '0;
                        chan_busy_q <= 1'b0;
                        drop_q      <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign grant_valid_o = grant_valid_q;
    assign grant_src_o   = grant_src_q;
    assign grant_dst_o   = grant_dst_q;
    assign chan_busy_o   = chan_busy_q;
    assign drop_o        = drop_q;
    assign req_err_o     = req_err_q;

endmodule

// File: tb/tb_ns_channel_arbiter.sv
// tb_ns_channel_arbiter: directed self-checking bench for ns_channel_arbiter.
module tb_ns_channel_arbiter;
    import ns_pkg::*;

`ifdef NS_CHANNEL_ARBITER_SNOOP_EN
    localparam int SL = 1;
`else
    localparam int SL = 0;
`endif

    logic       clk = 1'b0, rst = 1'b1;
    logic [2:0] send_req = '0, done = '0;
    logic [5:0] send_dst = '0;
    logic       grant_valid, chan_busy, drop, req_err, snoop_valid;
    logic [1:0] grant_src, grant_dst;
    int         n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    ns_channel_arbiter dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .send_req_i   (send_req),
        .send_dst_i   (send_dst),
        .done_i       (done),
        .grant_valid_o(grant_valid),
        .grant_src_o  (grant_src),
        .grant_dst_o  (grant_dst),
        .chan_busy_o  (chan_busy),
        .drop_o       (drop),
        .req_err_o    (req_err),
        .snoop_valid_o(snoop_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2);
        send_req = req;
        send_dst = {d2, d1, d0};
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gv"}, grant_valid, 0);
        check({tag, "_src"}, grant_src, 0);
        check({tag, "_dst"}, grant_dst, 0);
        check({tag, "_busy"}, chan_busy, 0);
        check({tag, "_drop"}, drop, 0);
        check({tag, "_err"}, req_err, 0);
        check({tag, "_snoop"}, snoop_valid, 0);
    endtask

    task automatic await_grant(input logic [1:0] s, input logic [1:0] d);
        for (int i = 0; i < 20 && !grant_valid; i++) tick;
        check("grant_seen", grant_valid, 1);
        check("grant_src", grant_src, s);
        check("grant_dst", grant_dst, d);
    endtask

    task automatic deliver(input logic [1:0] d);
        tick;
        if (snoop_valid) tick;
        done = 3'b001 << d;
        tick;
        done = '0;
    endtask

    initial begin
        repeat (2) tick;
        check_quiet("reset");

        // single message: grant at cycle 1, busy from cycle 2, done at cycle 4
        rst = 1'b0;
        drive(3'b001, 2'(RESPONDER_IDX), 2'd0, 2'd0);
        tick;
        check("t1_gv", grant_valid, 1);
        check("t1_src", grant_src, INITIATOR_IDX);
        check("t1_dst", grant_dst, RESPONDER_IDX);
        check("t1_busy_g", chan_busy, 0);
        drive(3'b000, 2'd1, 2'd0, 2'd0);
        tick;
        check("t1_gv_off", grant_valid, 0);
        check("t1_busy", chan_busy, 1);
        if (SL != 0) tick;
        repeat (2) tick;
        check("t1_busy4", chan_busy, 1);
        done = 3'b010;
        tick;
        done = '0;
        check("t1_idle", chan_busy, 0);
        check("t1_hold_src", grant_src, 0);
        check("t1_hold_dst", grant_dst, 1);
        check("t1_nodrop", drop, 0);

        // round robin from fresh reset: 0,1,2,0
        rst = 1'b1;
        tick;
        rst = 1'b0;
        drive(3'b111, 2'd1, 2'd2, 2'd0);
        for (int k = 0; k < 4; k++) begin
            await_grant(2'(k % 3), 2'((k + 1) % 3));
            deliver(2'((k + 1) % 3));
        end
        drive(3'b000, 2'd0, 2'd0, 2'd0);

        // self-addressed request: req_err every IDLE cycle, no grant
        drive(3'b001, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("self_err", req_err, 1);
            check("self_nogrant", grant_valid, 0);
        end
        drive(3'b001, 2'd2, 2'd0, 2'd0);
        tick;
        check("fix_gv", grant_valid, 1);
        check("fix_src", grant_src, 0);
        check("fix_dst", grant_dst, 2);
        check("fix_err", req_err, 0);
        drive(3'b000, 2'd0, 2'd0, 2'd0);
        deliver(2'd2);

        // out-of-range destination met before the winner: error and grant together
        drive(3'b110, 2'd0, 2'd3, 2'd0);
        tick;
        check("oor_gv", grant_valid, 1);
        check("oor_src", grant_src, 2);
        check("oor_dst", grant_dst, 0);
        check("oor_err", req_err, 1);
        drive(3'b000, 2'd0, 2'd0, 2'd0);
        deliver(2'd0);

        // illegal requester after the winner is not reported
        drive(3'b011, 2'd1, 2'd1, 2'd0);
        tick;
        check("late_gv", grant_valid, 1);
        check("late_src", grant_src, 0);
        check("late_err", req_err, 0);
        drive(3'b000, 2'd0, 2'd0, 2'd0);

        // no done: drop after six BUSY cycles
        tick;
        if (SL != 0) tick;
        for (int i = 0; i < 6; i++) begin
            check("to_busy", chan_busy, 1);
            check("to_nodrop", drop, 0);
            tick;
        end
        check("to_drop", drop, 1);
        check("to_idle", chan_busy, 0);
        tick;
        check("to_drop_pulse", drop, 0);

        // done on the timeout cycle wins; done on a foreign index is ignored
        drive(3'b001, 2'd1, 2'd0, 2'd0);
        await_grant(2'd0, 2'd1);
        drive(3'b000, 2'd0, 2'd0, 2'd0);
        tick;
        if (SL != 0) tick;
        done = 3'b100;
        tick;
        check("foreign_done", chan_busy, 1);
        done = '0;
        repeat (4) tick;
        check("edge_busy", chan_busy, 1);
        done = 3'b010;
        tick;
        done = '0;
        check("edge_nodrop", drop, 0);
        check("edge_idle", chan_busy, 0);
        tick;
        check("edge_nodrop2", drop, 0);

        // asynchronous reset while busy clears everything and rr priority
        drive(3'b001, 2'd1, 2'd0, 2'd0);
        await_grant(2'd0, 2'd1);
        drive(3'b000, 2'd0, 2'd0, 2'd0);
        tick;
        check("ar_busy", chan_busy, 1);
        #2 rst = 1'b1;
        #1 check_quiet("arst");
        tick;
        rst = 1'b0;
        drive(3'b011, 2'd2, 2'd0, 2'd0);
        await_grant(2'd0, 2'd2);
        drive(3'b000, 2'd0, 2'd0, 2'd0);
        deliver(2'd2);

`ifdef NS_CHANNEL_ARBITER_SNOOP_EN
        // intruder snoop slot after grant, skipped when the intruder sends
        drive(3'b001, 2'd1, 2'd0, 2'd0);
        await_grant(2'd0, 2'd1);
        drive(3'b000, 2'd0, 2'd0, 2'd0);
        tick;
        check("sn_valid", snoop_valid, 1);
        check("sn_src", grant_src, 2);
        check("sn_dst", grant_dst, 1);
        check("sn_busy", chan_busy, 1);
        tick;
        check("sn_off", snoop_valid, 0);
        check("sn_src_back", grant_src, 0);
        check("sn_busy2", chan_busy, 1);
        done = 3'b010;
        tick;
        done = '0;
        check("sn_idle", chan_busy, 0);
        drive(3'b100, 2'd0, 2'd0, 2'd0);
        await_grant(2'd2, 2'd0);
        drive(3'b000, 2'd0, 2'd0, 2'd0);
        tick;
        check("nosn_valid", snoop_valid, 0);
        check("nosn_busy", chan_busy, 1);
        check("nosn_src", grant_src, 2);
        done = 3'b001;
        tick;
        done = '0;
        check("nosn_idle", chan_busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ns_channel_arbiter.md
Name: ns_channel_arbiter

Overview:
- Schedules the single shared protocol channel (one message in flight) between initiator, responder and intruder agents.
- Replaces free nondeterministic selectS/selectO inputs with a fair round-robin grant and a delivery lock.
- Adds a stale-message timeout.
- Sits between the agents' request lines and the protocol model's selectS/selectO inputs.

Parameters:
- NUM_AGENTS, 3, number of agents; indices 0..NUM_AGENTS-1.
- MSB, 1, agent-index width minus 1.
- TIMEOUT, 6, BUSY cycles before an undelivered message is dropped; valid range 1..(2**TW)-1.
- TW, 3, timeout counter width.
- SNOOP_AGENT, 2, intruder index; used only with the optional feature.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-high reset.
- send_req, in, NUM_AGENTS, bit i set: agent i wants to send.
- send_dst, in, NUM_AGENTS*(MSB+1), packed destination per agent; agent i occupies slice [i*(MSB+1) +: MSB+1].
- done, in, NUM_AGENTS, bit d set: agent d consumed the in-flight message.
- grant_valid, out, 1, one-cycle send grant.
- grant_src, out, MSB+1, granted sender (selectS).
- grant_dst, out, MSB+1, granted destination (selectO).
- chan_busy, out, 1, message in flight.
- drop, out, 1, one-cycle pulse on timeout.
- req_err, out, 1, one-cycle pulse when an illegal request is skipped.
- snoop_valid, out, 1, snoop slot; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset values: grant_valid=0, grant_src=0, grant_dst=0, chan_busy=0, drop=0, req_err=0, snoop_valid=0. FSM in IDLE, timer=0, rr_last=NUM_AGENTS-1, so agent 0 has first priority.
- Reset asserted mid-operation aborts the in-flight message silently; drop is not pulsed.
- FSM states: IDLE, GRANT, SNOOP (optional feature only), BUSY.
- IDLE:
  - Scan agents starting at rr_last+1 mod NUM_AGENTS.
  - The first set send_req bit with a legal destination wins. Legal means dst != src and dst < NUM_AGENTS.
  - An illegal requester met before the winner is skipped and raises req_err for that cycle; at most one req_err pulse per cycle.
  - On a winner: latch src/dst, set rr_last=src, go to GRANT.
  - No legal request: stay in IDLE.
- GRANT:
  - grant_valid=1 for exactly this one cycle; grant_src/grant_dst hold the latched values.
  - Next state is BUSY, or SNOOP when the optional feature is enabled.
  - Latency from a req observed in IDLE to grant_valid is 1 cycle.
- BUSY:
  - chan_busy=1; grant_src/grant_dst hold their values; timer increments every cycle.
  - done[dst]=1: go to IDLE and clear timer.
  - done on any other index is ignored.
  - timer reaches TIMEOUT with no done[dst]: pulse drop and go to IDLE.
  - done[dst] and timeout in the same cycle: done wins, no drop.
- No new grant is issued while chan_busy=1; send_req may stay high without effect.
- Back-to-back traffic: IDLE is held at least one cycle between messages.
- grant_src/grant_dst keep their last values in IDLE.

Optional Feature:
- Macro: NS_CHANNEL_ARBITER_SNOOP_EN.
- Enabled:
  - After GRANT, spend one SNOOP cycle with snoop_valid=1, grant_src=SNOOP_AGENT, grant_dst=latched dst, chan_busy=1.
  - The intruder thereby sees every message before delivery; then go to BUSY.
  - When src==SNOOP_AGENT, SNOOP is skipped.
  - The timer does not run during SNOOP.
- Disabled: no SNOOP state; snoop_valid is constant 0; GRANT goes directly to BUSY.

Decomposition:
- Shared package ns_pkg holds:
  - typedef arb_state_t {IDLE, GRANT, SNOOP, BUSY};
  - the agent-index width;
  - constants for agent roles (initiator/responder/intruder index ranges), shared with the protocol model.
- One sub-module, ns_rr_pick: combinational rotating priority picker.
  - Inputs: masked request vector, rr_last.
  - Outputs: winner index, found flag.

Test Plan:
- After reset: send_req=3'b001, dst0=1 -> grant_valid at cycle 1 (src0, dst1); chan_busy from cycle 2; done[1] at cycle 4 -> IDLE at cycle 5.
- send_req=3'b111 held, each dst legal, done returned after 1 cycle -> grant order 0,1,2,0; no agent granted twice in a row.
- send_req=3'b001 with dst0=0 (self) -> req_err=1 every IDLE cycle, never grant_valid; set dst0=2 -> grant at the next cycle.
- Grant 0->1, withhold done -> drop pulse after 6 BUSY cycles; IDLE follows.
- Grant 0->1, done[1] and timeout in the same cycle -> no drop; done[2] alone during BUSY is ignored.
- Reset asserted during BUSY -> all outputs 0 immediately; next grant goes to agent 0.
- With NS_CHANNEL_ARBITER_SNOOP_EN: grant 0->1 -> snoop_valid=1 one cycle with grant_src=2; grant 2->0 -> no snoop cycle.
